// File: rtl/zbus_ay_dec.sv
// rtl/zbus_ay_dec.sv - Z80 I/O front-end: synchronises the bus, qualifies AY port accesses (#FFFD/#BFFD)
// Optional macro ZBUS_M1_FILTER_EN: reject IORQ+M1 (interrupt acknowledge) cycles.
module zbus_ay_dec #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       z_iorq_n,
  input  logic       z_rd_n,
  input  logic       z_wr_n,
  input  logic       z_m1_n,
  input  logic       z_a15,
  input  logic       z_a14,
  input  logic       z_a1,
  input  logic [7:0] d_in,
  output logic [7:0] d_lat,
  output logic       cfg_wrstb,
  output logic       addr_wrstb,
  output logic       data_wrstb,
  output logic       rd_active
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

`ifdef ZBUS_M1_FILTER_EN
  localparam int NS = 7;
  logic [NS-1:0] raw;
  assign raw = {z_m1_n, z_a1, z_a14, z_a15, z_wr_n, z_rd_n, z_iorq_n};
`else
  localparam int NS = 6;
  logic [NS-1:0] raw;
  logic          unused_m1;
  assign raw       = {z_a1, z_a14, z_a15, z_wr_n, z_rd_n, z_iorq_n};
  assign unused_m1 = z_m1_n;
`endif

  logic [SYNC_STAGES-1:0][NS-1:0] sync_q;
  logic [SYNC_STAGES-1:0]         prime_q;
  logic [NS-1:0]                  s;

  // prime_q marks when the synchroniser carries real bus samples rather than reset fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  logic       act;
  logic       wr_only;
  logic       rd_only;
  logic [2:0] cls;  // {rd_fffd, wr_bffd, wr_fffd}

  always_comb begin
    act = !s[0] && s[3] && !s[5];
`ifdef ZBUS_M1_FILTER_EN
    act = act && s[6];
`endif
    wr_only = !s[2] && s[1];
    rd_only = !s[1] && s[2];
    cls     = {act && rd_only && s[4], act && wr_only && !s[4], act && wr_only && s[4]};
  end

  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

  state_t        state_q;
  logic [2:0]    cls_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;

  assign cnt_d = cnt_q + CW'(1);

  always_comb begin
    accept = 1'b0;
    case (state_q)
      IDLE:    accept = (cls != 3'b000) && (STABLE_CYCLES == 1);
      QUAL:    accept = (cls == cls_q) && (cnt_d == CW'(STABLE_CYCLES));
      default: accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      cls_q      <= '0;
      cnt_q      <= '0;
      d_lat      <= 8'h00;
      cfg_wrstb  <= 1'b0;
      addr_wrstb <= 1'b0;
      data_wrstb <= 1'b0;
      rd_active  <= 1'b0;
    end else begin
      cfg_wrstb  <= 1'b0;
      addr_wrstb <= 1'b0;
      data_wrstb <= 1'b0;
      if (accept) begin
        state_q <= HOLD;
        cnt_q   <= '0;
        if (cls[2]) begin
          rd_active <= 1'b1;
        end else begin
          d_lat      <= d_in;
          data_wrstb <= cls[1];
          cfg_wrstb  <= cls[0] && (d_in[7:4] == 4'hF);
          addr_wrstb <= cls[0] && (d_in[7:4] != 4'hF);
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (cls != 3'b000) begin
              cls_q   <= cls;
              cnt_q   <= CW'(1);
              state_q <= QUAL;
            end
          end
          QUAL: begin
            if (cls == cls_q) begin
              cnt_q <= cnt_d;
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
          HOLD: begin
            if (prime_q[SYNC_STAGES-1] && s[0]) begin
              rd_active <= 1'b0;
              state_q   <= IDLE;
            end
          end
          default: state_q <= HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zbus_ay_dec.sv
// tb/tb_zbus_ay_dec.sv - self-checking bench for zbus_ay_dec (vector table, corner sequences, random vs model)
module tb_zbus_ay_dec;

  localparam int GAP    = 5;
  localparam int STABLE = 2;
`ifdef ZBUS_M1_FILTER_EN
  localparam bit M1_FILT = 1'b1;
`else
  localparam bit M1_FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iorq_n, rd_n, wr_n, m1_n, a15, a14, a1;
  logic [7:0] d;
  logic [7:0] o_dlat;
  logic       o_cfg, o_addr, o_data, o_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  zbus_ay_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .z_iorq_n  (iorq_n),
    .z_rd_n    (rd_n),
    .z_wr_n    (wr_n),
    .z_m1_n    (m1_n),
    .z_a15     (a15),
    .z_a14     (a14),
    .z_a1      (a1),
    .d_in      (d),
    .d_lat     (o_dlat),
    .cfg_wrstb (o_cfg),
    .addr_wrstb(o_addr),
    .data_wrstb(o_data),
    .rd_active (o_rd)
  );

  typedef struct {
    logic        io, r, w, m;
    logic [15:0] a;
    logic [7:0]  dv;
    int          n;
    logic [3:0]  e;     // {rd, data, addr, cfg}
    logic [7:0]  e_dlat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    m1_n   = 1'b1;
  endtask

  task automatic drive(input logic io, r, w, m, input logic [15:0] a, input logic [7:0] dv);
    iorq_n = io;
    rd_n   = r;
    wr_n   = w;
    m1_n   = m;
    a15    = a[15];
    a14    = a[14];
    a1     = a[1];
    d      = dv;
  endtask

  // Holds one bus cycle for n clocks, then idles GAP clocks; samples every cycle from E0.
  task automatic run_txn(input logic io, r, w, m, input logic [15:0] a, input logic [7:0] dv,
                         input int n, output int c_cfg, output int c_addr, output int c_data,
                         output int first_stb, output int rd_first, output int rd_last, output int viol);
    logic [2:0] prev, cur;
    c_cfg = 0; c_addr = 0; c_data = 0;
    first_stb = -1; rd_first = -1; rd_last = -1; viol = 0;
    prev = 3'b000;
    drive(io, r, w, m, a, dv);
    for (int i = 0; i < n + GAP; i++) begin
      step();
      cur = {o_cfg, o_addr, o_data};
      if ($countones(cur) > 1) viol++;
      if (cur != 3'b000 && prev != 3'b000) viol++;
      if (cur != 3'b000 && first_stb < 0) first_stb = i;
      c_cfg  += int'(o_cfg);
      c_addr += int'(o_addr);
      c_data += int'(o_data);
      if (o_rd) begin
        if (rd_first < 0) rd_first = i;
        rd_last = i;
      end
      prev = cur;
      if (i == n - 1) bus_idle();
    end
  endtask

  // Outcome of a clean bus cycle held n clocks, straight from the decode rules.
  function automatic logic [3:0] model(input logic io, r, w, m, input logic [15:0] a,
                                       input logic [7:0] dv, input int n);
    bit act, wr, rd;
    act = !io && a[15] && !a[1] && (m || !M1_FILT);
    wr  = !w && r;
    rd  = !r && w;
    if (!act || n < STABLE) return 4'b0000;
    if (wr && !a[14]) return 4'b0100;
    if (wr) return (dv[7:4] == 4'hF) ? 4'b0001 : 4'b0010;
    if (rd && a[14]) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic vec_t mk(input logic io, r, w, m, input logic [15:0] a, input logic [7:0] dv,
                              input int n, input logic [3:0] e, input logic [7:0] e_dlat);
    vec_t v;
    v.io = io; v.r = r; v.w = w; v.m = m; v.a = a; v.dv = dv; v.n = n;
    v.e = e; v.e_dlat = e_dlat;
    return v;
  endfunction

  function automatic logic [31:0] pack(input int c_cfg, c_addr, c_data, input bit rd);
    return {7'd0, rd, 8'(c_data), 8'(c_addr), 8'(c_cfg)};
  endfunction

  function automatic logic [31:0] epack(input logic [3:0] e);
    return {7'd0, e[3], 7'd0, e[2], 7'd0, e[1], 7'd0, e[0]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c_cfg, c_addr, c_data, fs, rf, rl, viol, nstb;
    logic [7:0] dl_exp;

    tbl[0]  = mk(0, 1, 0, 1, 16'hFFFD, 8'h07, 10, 4'b0010, 8'h07);
    tbl[1]  = mk(0, 1, 0, 1, 16'hBFFD, 8'h3E, 10, 4'b0100, 8'h3E);
    tbl[2]  = mk(0, 1, 0, 1, 16'hFFFD, 8'hF5, 1,  4'b0000, 8'h3E);
    tbl[3]  = mk(0, 0, 1, 1, 16'hBFFD, 8'hA5, 8,  4'b0000, 8'h3E);
    tbl[4]  = mk(0, 0, 1, 1, 16'hFFFD, 8'hA5, 8,  4'b1000, 8'h3E);
    tbl[5]  = mk(0, 1, 0, 1, 16'hFFFD, 8'hF0, 2,  4'b0001, 8'hF0);
    tbl[6]  = mk(0, 1, 0, 1, 16'hFFFD, 8'hE9, 2,  4'b0010, 8'hE9);
    tbl[7]  = mk(0, 0, 0, 1, 16'hFFFD, 8'h11, 6,  4'b0000, 8'hE9);
    tbl[8]  = mk(0, 1, 0, 1, 16'hFFFF, 8'h22, 5,  4'b0000, 8'hE9);
    tbl[9]  = mk(0, 1, 0, 1, 16'h7FFD, 8'h33, 5,  4'b0000, 8'hE9);
    tbl[10] = mk(1, 1, 0, 1, 16'hFFFD, 8'h55, 5,  4'b0000, 8'hE9);
    tbl[11] = mk(0, 0, 1, 0, 16'hFFFD, 8'hA5, 6,  M1_FILT ? 4'b0000 : 4'b1000, 8'hE9);
    tbl[12] = mk(0, 1, 0, 0, 16'hBFFD, 8'h44, 6,  M1_FILT ? 4'b0000 : 4'b0100,
                 M1_FILT ? 8'hE9 : 8'h44);

    // Reset with a write already on the bus: it must be ignored.
    rst_n = 1'b0;
    drive(0, 1, 0, 1, 16'hFFFD, 8'hF3);
    repeat (3) step();
    chk("reset_dlat", 0, 32'(o_dlat), 32'h00);
    chk("reset_outs", 0, {28'd0, o_cfg, o_addr, o_data, o_rd}, 32'h0);
    rst_n = 1'b1;
    nstb = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      nstb += int'(o_cfg | o_addr | o_data | o_rd);
    end
    chk("active_at_reset_stb", 0, 32'(nstb), 32'd0);
    chk("active_at_reset_dlat", 0, 32'(o_dlat), 32'h00);
    bus_idle();
    repeat (4) step();
    run_txn(0, 1, 0, 1, 16'hFFFD, 8'hF3, 10, c_cfg, c_addr, c_data, fs, rf, rl, viol);
    chk("first_cfg_cnt", 0, pack(c_cfg, c_addr, c_data, rf >= 0), epack(4'b0001));
    chk("first_cfg_latency", 0, 32'(fs), 32'd3);
    chk("first_cfg_dlat", 0, 32'(o_dlat), 32'hF3);

    // Read timing: rises at E3, falls one edge after synchronised IORQ goes high.
    run_txn(0, 0, 1, 1, 16'hFFFD, 8'h5A, 8, c_cfg, c_addr, c_data, fs, rf, rl, viol);
    chk("rd_rise", 0, 32'(rf), 32'd3);
    chk("rd_fall", 0, 32'(rl), 32'd9);
    chk("rd_no_stb", 0, 32'(c_cfg + c_addr + c_data), 32'd0);
    chk("rd_dlat", 0, 32'(o_dlat), 32'hF3);

    // Reset pulse while a write is qualifying.
    drive(0, 1, 0, 1, 16'hFFFD, 8'hFF);
    nstb = 0;
    repeat (3) begin
      step();
      nstb += int'(o_cfg | o_addr | o_data);
    end
    rst_n = 1'b0;
    step();
    nstb += int'(o_cfg | o_addr | o_data);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      nstb += int'(o_cfg | o_addr | o_data);
    end
    chk("rst_qual_stb", 0, 32'(nstb), 32'd0);
    chk("rst_qual_dlat", 0, 32'(o_dlat), 32'h00);
    bus_idle();
    repeat (GAP) step();

    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i].io, tbl[i].r, tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].dv, tbl[i].n,
              c_cfg, c_addr, c_data, fs, rf, rl, viol);
      chk("vec_strobes", i, pack(c_cfg, c_addr, c_data, rf >= 0), epack(tbl[i].e));
      chk("vec_dlat", i, 32'(o_dlat), 32'(tbl[i].e_dlat));
      chk("vec_excl", i, 32'(viol), 32'd0);
      chk("vec_rd_end", i, 32'(o_rd), 32'd0);
    end

    dl_exp = tbl[12].e_dlat;
    for (int i = 0; i < 40; i++) begin
      logic        io, r, w, m;
      logic [15:0] a;
      logic [7:0]  dv;
      logic [3:0]  e;
      int          n, mode;
      io    = ($urandom % 5 == 0);
      a     = 16'($urandom);
      a[15] = ($urandom % 4 != 0);
      a[1]  = ($urandom % 4 == 0);
      mode  = int'($urandom % 4);
      w     = !(mode == 0 || mode == 2);
      r     = !(mode == 1 || mode == 2);
      m     = ($urandom % 4 != 0);
      dv    = 8'($urandom);
      n     = 1 + int'($urandom % 5);
      e     = model(io, r, w, m, a, dv, n);
      if (e[2:0] != 3'b000) dl_exp = dv;
      run_txn(io, r, w, m, a, dv, n, c_cfg, c_addr, c_data, fs, rf, rl, viol);
      chk("rand_strobes", i, pack(c_cfg, c_addr, c_data, rf >= 0), epack(e));
      chk("rand_dlat", i, 32'(o_dlat), 32'(dl_exp));
      chk("rand_excl", i, 32'(viol), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
